// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Divisor legality and half-period arithmetic are kept here so every user agrees on them.
package clk_div_pkg;

    localparam int          CNT_W_DEF = 8;
    localparam int unsigned DIV_MIN   = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

    function automatic logic [31:0] div_half(input logic [31:0] n);
        return n >> 1;
    endfunction

    function automatic logic div_legal(input logic [31:0] v);
        return v >= DIV_MIN;
    endfunction

endpackage

// File: rtl/clk_div_phase.sv
// Output phase generator: posedge phase flop plus the single negedge flop that
// stretches odd-ratio high times by half a clk period.
module clk_div_phase
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] n,
    output logic             clk_out
);

    logic [CNT_W-1:0] half;
    logic             pos_q, pos_d;
    logic             odd_q, odd_d;
    logic             neg_q;

    // For odd n, n>>1 equals (n-1)/2, so one threshold serves both parities.
    always_comb begin
        half  = CNT_W'(div_half(32'(n)));
        pos_d = run && (cnt < half);
        odd_d = run ? n[0] : odd_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q <= 1'b0;
            odd_q <= 1'b0;
        end else begin
            pos_q <= pos_d;
            odd_q <= odd_d;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    // neg_q trails pos_q by half a cycle, so the OR never dips between them.
    assign clk_out = pos_q | (odd_q & neg_q);

endmodule

// File: rtl/clk_divider_prog.sv
// Runtime-programmable 50%-duty clock divider with boundary-synchronised
// divisor loads, graceful stop on en deassertion and a period-start strobe.
module clk_divider_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             div_err,
    output logic             div_pending,
    output logic [CNT_W-1:0] cur_div,
    output logic             clk_out,
    output logic             clk_pulse
);

    run_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] active_div_q, active_div_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             pend_vld_q, pend_vld_d;
    logic             div_err_q, div_err_d;
    logic             pulse_q, pulse_d;

    logic             running;
    logic             run_now;
    logic             boundary;
    logic             apply;
    logic [CNT_W-1:0] n_eff;
    logic [CNT_W-1:0] eval_cnt;

    always_comb begin
        running  = (state_q == ST_RUN);
        run_now  = running || en;
        // When idle a waiting divisor takes effect immediately, including on a restart edge.
        n_eff    = (!running && pend_vld_q) ? pending_q : active_div_q;
        eval_cnt = running ? cnt_q : '0;
        boundary = running && (eval_cnt == n_eff - CNT_W'(1));
        apply    = pend_vld_q && (boundary || !running);

        state_d = state_q;
        if (running) begin
            if (boundary && !en) begin
                state_d = ST_IDLE;
            end
        end else if (en) begin
            state_d = ST_RUN;
        end

        cnt_d = '0;
        if (run_now && !boundary) begin
            cnt_d = eval_cnt + CNT_W'(1);
        end

        pulse_d      = run_now && (eval_cnt == '0);
        active_div_d = apply ? pending_q : active_div_q;
        pending_d    = pending_q;
        pend_vld_d   = pend_vld_q && !apply;
        div_err_d    = 1'b0;

        // A load on the applying edge overrides the clear and waits for the next boundary.
        if (div_load) begin
            if (div_legal(32'(div_val))) begin
                pending_d  = div_val;
                pend_vld_d = 1'b1;
            end else begin
                div_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            active_div_q <= CNT_W'(DEF_DIV);
            pending_q    <= '0;
            pend_vld_q   <= 1'b0;
            div_err_q    <= 1'b0;
            pulse_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            active_div_q <= active_div_d;
            pending_q    <= pending_d;
            pend_vld_q   <= pend_vld_d;
            div_err_q    <= div_err_d;
            pulse_q      <= pulse_d;
        end
    end

    clk_div_phase #(
        .CNT_W (CNT_W)
    ) u_phase (
        .clk     (clk),
        .rst     (rst),
        .run     (run_now),
        .cnt     (eval_cnt),
        .n       (n_eff),
        .clk_out (clk_out)
    );

    assign div_err     = div_err_q;
    assign div_pending = pend_vld_q;
    assign cur_div     = active_div_q;
    assign clk_pulse   = pulse_q;

endmodule
